// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared width default and opcode encodings for the bus ALU datapath
package alu_pkg;

    localparam int DATA_WIDTH = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU, modulo 2^WIDTH, carry/borrow discarded
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOT:  y = ~a;
            OP_SHL:  y = {a[WIDTH-2:0], 1'b0};
            OP_SHR:  y = {1'b0, a[WIDTH-1:1]};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_bus_datapath.sv
// rtl/alu_bus_datapath.sv - operand/result registers around alu_core with a tri-state bus driver
module alu_bus_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] bus,
    input  logic [2:0]       opControl,
    input  logic             ALUin0,
    input  logic             ALUin1,
    input  logic             ALUOutLatch,
    input  logic             ALUOutEn
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] alu_y;

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .a  (a_q),
        .b  (b_q),
        .op (opControl),
        .y  (alu_y)
    );

    // R samples the ALU output from pre-edge operands, so a same-edge load cannot leak in.
    always_comb begin
        a_d = ALUin0      ? bus   : a_q;
        b_d = ALUin1      ? bus   : b_q;
        r_d = ALUOutLatch ? alu_y : r_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            r_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            r_q <= r_d;
        end
    end

    assign bus = (ALUOutEn && !rst) ? r_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_bus_datapath.sv
// tb/tb_alu_bus_datapath.sv - directed self-checking bench for alu_bus_datapath
module tb_alu_bus_datapath;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic [2:0]   opControl;
    logic         ALUin0;
    logic         ALUin1;
    logic         ALUOutLatch;
    logic         ALUOutEn;
    logic [W-1:0] tb_drv;
    logic         tb_en;
    wire  [W-1:0] bus;

    int tests_run;
    int tests_failed;

    assign bus = tb_en ? tb_drv : {W{1'bz}};

    alu_bus_datapath #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .opControl   (opControl),
        .ALUin0      (ALUin0),
        .ALUin1      (ALUin1),
        .ALUOutLatch (ALUOutLatch),
        .ALUOutEn    (ALUOutEn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_a(input logic [W-1:0] v);
        @(negedge clk);
        ALUOutEn = 1'b0;
        tb_en    = 1'b1;
        tb_drv   = v;
        ALUin0   = 1'b1;
        @(posedge clk);
        #1;
        ALUin0 = 1'b0;
        tb_en  = 1'b0;
    endtask

    task automatic load_b(input logic [W-1:0] v);
        @(negedge clk);
        ALUOutEn = 1'b0;
        tb_en    = 1'b1;
        tb_drv   = v;
        ALUin1   = 1'b1;
        @(posedge clk);
        #1;
        ALUin1 = 1'b0;
        tb_en  = 1'b0;
    endtask

    // Latch the result for op, then enable the output driver; leaves ALUOutEn high.
    task automatic latch_op(input logic [2:0] op);
        @(negedge clk);
        ALUOutEn    = 1'b0;
        tb_en       = 1'b0;
        opControl   = op;
        ALUOutLatch = 1'b1;
        @(posedge clk);
        #1;
        ALUOutLatch = 1'b0;
        ALUOutEn    = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ALUOutEn = 1'b1;
        #1;
        tests_run++;
        if (bus !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_r_value: got %h expected %h", bus, 16'h0000);
        end
        load_a(16'h0005);
        load_b(16'h0003);
        latch_op(3'b000);
        tests_run++;
        if (bus !== 16'h0008) begin
            tests_failed++;
            $display("FAIL pre_reset_add: got %h expected %h", bus, 16'h0008);
        end
        // Mid-cycle reset with output enabled: only the bench's zero drive may remain.
        @(posedge clk);
        #2;
        tb_drv = 16'h0000;
        tb_en  = 1'b1;
        rst    = 1'b1;
        #1;
        tests_run++;
        if (bus !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_bus_release: got %h expected %h", bus, 16'h0000);
        end
        @(negedge clk);
        rst   = 1'b0;
        tb_en = 1'b0;
        latch_op(3'b000);
        tests_run++;
        if (bus !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_clears_regs: got %h expected %h", bus, 16'h0000);
        end
    endtask

    task automatic test_ops;
        logic [2:0]   ops [8];
        logic [W-1:0] exp [8];
        ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
        exp = '{16'h9544, 16'h70DC, 16'h0210, 16'h9334,
                16'h9124, 16'h7CEF, 16'h0620, 16'h4188};
        load_a(16'h8310);
        load_b(16'h1234);
        for (int i = 0; i < 8; i++) begin
            latch_op(ops[i]);
            tests_run++;
            if (bus !== exp[i]) begin
                tests_failed++;
                $display("FAIL op_%0d: got %h expected %h", i, bus, exp[i]);
            end
        end
    endtask

    task automatic test_wrap;
        load_a(16'hFFFF);
        load_b(16'h0001);
        latch_op(3'b000);
        tests_run++;
        if (bus !== 16'h0000) begin
            tests_failed++;
            $display("FAIL add_wrap: got %h expected %h", bus, 16'h0000);
        end
        load_a(16'h0000);
        latch_op(3'b001);
        tests_run++;
        if (bus !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL sub_wrap: got %h expected %h", bus, 16'hFFFF);
        end
    endtask

    task automatic test_same_edge;
        load_a(16'h0001);
        load_b(16'h0001);
        @(negedge clk);
        ALUOutEn    = 1'b0;
        opControl   = 3'b000;
        tb_drv      = 16'h0010;
        tb_en       = 1'b1;
        ALUin0      = 1'b1;
        ALUOutLatch = 1'b1;
        @(posedge clk);
        #1;
        ALUin0      = 1'b0;
        ALUOutLatch = 1'b0;
        tb_en       = 1'b0;
        ALUOutEn    = 1'b1;
        #1;
        tests_run++;
        if (bus !== 16'h0002) begin
            tests_failed++;
            $display("FAIL same_edge_r: got %h expected %h", bus, 16'h0002);
        end
    endtask

    task automatic test_tristate_feedback;
        @(negedge clk);
        ALUOutEn = 1'b0;
        tb_drv   = 16'hA5A5;
        tb_en    = 1'b1;
        #1;
        tests_run++;
        if (bus !== 16'hA5A5) begin
            tests_failed++;
            $display("FAIL tristate_ext_a5a5: got %h expected %h", bus, 16'hA5A5);
        end
        tb_drv = 16'h0000;
        #1;
        tests_run++;
        if (bus !== 16'h0000) begin
            tests_failed++;
            $display("FAIL tristate_ext_0000: got %h expected %h", bus, 16'h0000);
        end
        @(negedge clk);
        tb_en    = 1'b0;
        ALUOutEn = 1'b1;
        ALUin1   = 1'b1;
        #1;
        tests_run++;
        if (bus !== 16'h0002) begin
            tests_failed++;
            $display("FAIL feedback_bus: got %h expected %h", bus, 16'h0002);
        end
        @(posedge clk);
        #1;
        ALUin1 = 1'b0;
        // A=0x0010 from the same-edge load, B=0x0002 from feedback.
        latch_op(3'b000);
        tests_run++;
        if (bus !== 16'h0012) begin
            tests_failed++;
            $display("FAIL feedback_operands: got %h expected %h", bus, 16'h0012);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        opControl    = 3'b000;
        ALUin0       = 1'b0;
        ALUin1       = 1'b0;
        ALUOutLatch  = 1'b0;
        ALUOutEn     = 1'b0;
        tb_drv       = '0;
        tb_en        = 1'b0;

        test_reset();
        test_ops();
        test_wrap();
        test_same_edge();
        test_tristate_feedback();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
